// File: rtl/cpu32_pkg.sv
// cpu32_pkg: definitions shared by the CPU front end.
//   fetch_state_e        : fetch FSM states (IDLE, REQ, DROP)
//   WORD_W               : instruction/data word width
//   REG_ST/LR/SP/PC      : special register indices in the 32-entry register file
package cpu32_pkg;

  localparam int unsigned WORD_W = 32;

  localparam int unsigned REG_ST = 28;
  localparam int unsigned REG_LR = 29;
  localparam int unsigned REG_SP = 30;
  localparam int unsigned REG_PC = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x DW circular queue with synchronous clear.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_push, i_wdata  : write an entry (ignored when full and not popping)
//   i_pop            : drop the head entry (ignored when empty)
//   i_clear          : empty the queue; wins over push/pop in the same cycle
//   o_rdata          : head entry, zero when empty
//   o_full, o_empty  : occupancy flags
//   o_count          : occupancy, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 64,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_pop  = i_pop & ~o_empty;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign w_push = i_push & (~o_full | w_pop);

  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode from a small queue.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   pc_in                : current PC (r31) from the register file
//   pc_incr              : one-cycle pulse per issued fetch, advances r31
//   flush                : PC redirect; drops queued and in-flight fetches
//   mem_req/mem_addr     : instruction memory read request, held until mem_ack
//   mem_ack/mem_rdata    : read completion and returned word
//   ir/ir_pc/ir_valid    : head-of-queue instruction, its PC, queue non-empty
//   ir_ready             : decode pops the head when ir_valid is high
// Build option: define FETCH_B2B_EN to issue the next fetch in the ack cycle,
// giving one fetch per cycle with a single-cycle memory.
module fetch_unit
  import cpu32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PW-1:0]     pc_in,
  output logic              pc_incr,
  input  logic              flush,
  output logic              mem_req,
  output logic [PW-1:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir,
  output logic [PW-1:0]     ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e r_state;

  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue_idle;
  logic                 w_b2b;
  logic [WORD_W+PW-1:0] w_head;

  assign w_pop  = ir_valid & ir_ready;
  assign w_push = (r_state == REQ) & mem_ack & ~flush;

  assign w_issue_idle = (r_state == IDLE) & ~flush & ~w_full;

`ifdef FETCH_B2B_EN
  // Space left after this push: count+1-pop < DEPTH.
  assign w_b2b = w_push & (w_pop ? (w_count < CW'(DEPTH)) : (w_count < CW'(DEPTH - 1)));
`else
  assign w_b2b = 1'b0;
`endif

  // Gated by rst so the register file never sees an increment during reset.
  assign pc_incr = (w_issue_idle | w_b2b) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue_idle) begin
            mem_addr <= pc_in;
            mem_req  <= 1'b1;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (w_b2b) begin
              mem_addr <= pc_in;
            end else begin
              mem_req <= 1'b0;
              r_state <= IDLE;
            end
          end else if (flush) begin
            // Request cannot be withdrawn; swallow its data when it lands.
            r_state <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (WORD_W + PW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_wdata ({mem_addr, mem_rdata}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign ir_valid = ~w_empty;
  assign ir       = w_head[WORD_W-1:0];
  assign ir_pc    = w_head[WORD_W+PW-1:WORD_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (DEPTH=2, PW=32).
// Models the register-file PC (increment / flush write) and a scripted memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = 32'h100;
  logic        pc_incr;
  logic        flush = 1'b0;
  logic [31:0] flush_tgt = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;

  logic        auto_ack = 1'b0;
  logic        r_ack = 1'b0;
  logic [31:0] r_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  assign mem_ack   = auto_ack ? mem_req : r_ack;
  assign mem_rdata = auto_ack ? {16'hC0DE, mem_addr[15:0]} : r_rdata;

  always #5 clk = ~clk;

  // Register-file r31: a flush write wins, increment otherwise.
  always @(posedge clk) begin
    if (flush) pc_in <= flush_tgt;
    else if (pc_incr) pc_in <= pc_in + 32'd1;
  end

  fetch_unit #(
    .DEPTH (2),
    .PW    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_incr   (pc_incr),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_incr;
    int n_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_n_incr;
    logic [31:0] exp_n_valid;

    // Power-on reset
    #1 rst = 1'b1;
    #1;
    chk("por_mem_req", {31'b0, mem_req}, 32'h0);
    chk("por_pc_incr", {31'b0, pc_incr}, 32'h0);
    chk("por_ir_valid", {31'b0, ir_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t1_issue_incr", {31'b0, pc_incr}, 32'h1);

    // Single fetch, ack two cycles after the request
    tick();
    chk("t1_req", {31'b0, mem_req}, 32'h1);
    chk("t1_addr", mem_addr, 32'h100);
    #1 chk("t1_incr_once", {31'b0, pc_incr}, 32'h0);
    tick();
    chk("t1_req_hold", {31'b0, mem_req}, 32'h1);
    chk("t1_addr_hold", mem_addr, 32'h100);
    r_ack = 1'b1;
    r_rdata = 32'hDEADBEEF;
    tick();
    r_ack = 1'b0;
    chk("t1_valid", {31'b0, ir_valid}, 32'h1);
    chk("t1_ir", ir, 32'hDEADBEEF);
    chk("t1_ir_pc", ir_pc, 32'h100);
    chk("t1_req_drop", {31'b0, mem_req}, 32'h0);
    #1 chk("t2_issue_incr", {31'b0, pc_incr}, 32'h1);

    // Backpressure: fill both entries, then stall
    tick();
    chk("t2_addr", mem_addr, 32'h101);
    r_ack = 1'b1;
    r_rdata = 32'h11111111;
    tick();
    r_ack = 1'b0;
    chk("t2_full_no_req", {31'b0, mem_req}, 32'h0);
    chk("t2_head_pc", ir_pc, 32'h100);
    #1 chk("t2_full_no_incr", {31'b0, pc_incr}, 32'h0);
    tick();
    chk("t2_still_no_req", {31'b0, mem_req}, 32'h0);
    chk("t2_still_no_incr", {31'b0, pc_incr}, 32'h0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("t2_pop_ir_pc", ir_pc, 32'h101);
    chk("t2_pop_ir", ir, 32'h11111111);
    #1 chk("t2_resume_incr", {31'b0, pc_incr}, 32'h1);
    tick();
    chk("t2_resume_req", {31'b0, mem_req}, 32'h1);
    chk("t2_resume_addr", mem_addr, 32'h102);

    // Flush while REQ, ack three cycles later
    flush = 1'b1;
    flush_tgt = 32'h200;
    #1 chk("t3_flush_no_incr", {31'b0, pc_incr}, 32'h0);
    tick();
    flush = 1'b0;
    chk("t3_cleared", {31'b0, ir_valid}, 32'h0);
    chk("t3_req_held", {31'b0, mem_req}, 32'h1);
    chk("t3_addr_held", mem_addr, 32'h102);
    tick();
    chk("t3_req_held2", {31'b0, mem_req}, 32'h1);
    tick();
    chk("t3_req_held3", {31'b0, mem_req}, 32'h1);
    r_ack = 1'b1;
    r_rdata = 32'hBAD0BAD0;
    tick();
    r_ack = 1'b0;
    chk("t3_drop_req", {31'b0, mem_req}, 32'h0);
    chk("t3_not_pushed", {31'b0, ir_valid}, 32'h0);
    #1 chk("t3_reissue_incr", {31'b0, pc_incr}, 32'h1);
    tick();
    chk("t3_new_addr", mem_addr, 32'h200);

    // Flush coincident with ack, one entry queued
    r_ack = 1'b1;
    r_rdata = 32'hAAAA0200;
    tick();
    r_ack = 1'b0;
    chk("t4_one_entry", {31'b0, ir_valid}, 32'h1);
    chk("t4_ir_pc", ir_pc, 32'h200);
    tick();
    chk("t4_addr", mem_addr, 32'h201);
    r_ack = 1'b1;
    r_rdata = 32'hBBBB0201;
    flush = 1'b1;
    flush_tgt = 32'h300;
    #1 chk("t4_flush_no_incr", {31'b0, pc_incr}, 32'h0);
    tick();
    r_ack = 1'b0;
    flush = 1'b0;
    chk("t4_empty", {31'b0, ir_valid}, 32'h0);
    chk("t4_ir_zero", ir, 32'h0);
    chk("t4_ir_pc_zero", ir_pc, 32'h0);
    chk("t4_req_low", {31'b0, mem_req}, 32'h0);

    // Flush in IDLE suppresses the issue
    flush = 1'b1;
    flush_tgt = 32'h400;
    #1 chk("t5_idle_flush_no_incr", {31'b0, pc_incr}, 32'h0);
    tick();
    flush = 1'b0;
    chk("t5_no_issue", {31'b0, mem_req}, 32'h0);
    #1 chk("t5_issue_incr", {31'b0, pc_incr}, 32'h1);
    tick();
    chk("t5_addr", mem_addr, 32'h400);

    // Streaming with a single-cycle memory and decode always ready
    auto_ack = 1'b1;
    ir_ready = 1'b1;
    n_incr = 0;
    n_valid = 0;
    exp_pc = 32'h400;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (pc_incr) n_incr++;
      if (ir_valid) begin
        n_valid++;
        chk("t6_ir_pc", ir_pc, exp_pc);
        chk("t6_ir", ir, {16'hC0DE, exp_pc[15:0]});
        exp_pc = exp_pc + 32'd1;
      end
      tick();
    end
`ifdef FETCH_B2B_EN
    exp_n_incr = 32'd8;
    exp_n_valid = 32'd7;
`else
    exp_n_incr = 32'd4;
    exp_n_valid = 32'd4;
`endif
    chk("t6_incr_count", 32'(n_incr), exp_n_incr);
    chk("t6_valid_count", 32'(n_valid), exp_n_valid);
    auto_ack = 1'b0;
    ir_ready = 1'b0;

    // Asynchronous reset with a request outstanding
    for (int i = 0; i < 4; i++) begin
      if (!mem_req) tick();
    end
    chk("t7_pre_req", {31'b0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_req", {31'b0, mem_req}, 32'h0);
    chk("t7_rst_addr", mem_addr, 32'h0);
    chk("t7_rst_incr", {31'b0, pc_incr}, 32'h0);
    chk("t7_rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("t7_rst_ir", ir, 32'h0);
    chk("t7_rst_ir_pc", ir_pc, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t7_idle_req", {31'b0, mem_req}, 32'h0);
    chk("t7_idle_incr", {31'b0, pc_incr}, 32'h1);
    exp_pc = pc_in;
    tick();
    chk("t7_reissue_req", {31'b0, mem_req}, 32'h1);
    chk("t7_reissue_addr", mem_addr, exp_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
